// File: rtl/pes_ram_pkg.sv
// Shared definitions for the Wishbone-to-dual-port-RAM bridge:
// FSM encoding, register offsets and CTRL field positions.
package pes_ram_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    ACK  = 3'd4,
    FILL = 3'd5
  } state_t;

  // Byte offset of the CTRL register inside the 4 KiB window
  localparam logic [8:0]  CTRL_OFFSET = 9'h100;

  // CTRL write fields
  localparam int unsigned START_BIT = 0;
  localparam int unsigned SEED_LSB  = 8;
  localparam int unsigned SEED_W    = 8;

endpackage

// File: rtl/ram_fill_gen.sv
// Fill pattern generator: walks addresses 0..2^AW-1 once per load,
// producing seed+i for port A and its complement for port B.
module ram_fill_gen
  import pes_ram_pkg::*;
#(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] seed_in,
  input  logic          step,
  output logic [AW-1:0] idx,
  output logic          done,
  output logic [DW-1:0] pat_a_c,
  output logic [DW-1:0] pat_b_c
);

  logic [DW-1:0] seed;

  // Counter saturates at the last address and raises done instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed <= '0;
      idx  <= '0;
      done <= 1'b0;
    end else if (load) begin
      seed <= seed_in;
      idx  <= '0;
      done <= 1'b0;
    end else if (step) begin
      if (idx == {AW{1'b1}}) begin
        done <= 1'b1;
      end else begin
        idx <= idx + AW'(1);
      end
    end
  end

  assign pat_a_c = seed + DW'(idx);
  assign pat_b_c = ~pat_a_c;

endmodule

// File: rtl/wb_ram_bridge.sv
// Wishbone classic slave bridging a 4 KiB window onto a dual-port RAM,
// with a CTRL register that launches a self-timed pattern fill.
module wb_ram_bridge
  import pes_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned AW        = 6,
  parameter int unsigned DW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic [AW-1:0] ram_addr_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_a,
  output logic [DW-1:0] ram_data_b,
  output logic          ram_we_a,
  output logic          ram_we_b,
  input  logic [DW-1:0] ram_q_a,
  input  logic [DW-1:0] ram_q_b,
  output logic          busy_o
);

  state_t        state, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_a_d, data_b_d;
  logic          we_a_d, we_b_d, ack_d, busy_d;
  logic [31:0]   dat_d;
  logic          fill_pend, fill_pend_d;

  logic          req_hit_c, ram_win_c, ctrl_hit_c, fill_req_c;
  logic          gen_load, gen_step, gen_done;
  logic [AW-1:0] gen_idx;
  logic [DW-1:0] gen_pat_a, gen_pat_b;
  logic          unused_bits;

  assign req_hit_c  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign ram_win_c  = ~wbs_adr_i[8];
  assign ctrl_hit_c = (wbs_adr_i[8:2] == CTRL_OFFSET[8:2]);
  assign fill_req_c = ctrl_hit_c & wbs_we_i & wbs_sel_i[0] & wbs_dat_i[START_BIT];

  assign unused_bits = ^{wbs_adr_i[11:9], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  ram_fill_gen #(.AW(AW), .DW(DW)) u_fill (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (gen_load),
    .seed_in (DW'(wbs_dat_i[SEED_LSB +: SEED_W])),
    .step    (gen_step),
    .idx     (gen_idx),
    .done    (gen_done),
    .pat_a_c (gen_pat_a),
    .pat_b_c (gen_pat_b)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      ram_data_a <= '0;
      ram_data_b <= '0;
      ram_we_a   <= 1'b0;
      ram_we_b   <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      busy_o     <= 1'b0;
      fill_pend  <= 1'b0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      ram_data_a <= data_a_d;
      ram_data_b <= data_b_d;
      ram_we_a   <= we_a_d;
      ram_we_b   <= we_b_d;
      wbs_ack_o  <= ack_d;
      wbs_dat_o  <= dat_d;
      busy_o     <= busy_d;
      fill_pend  <= fill_pend_d;
    end
  end

  assign ram_addr_a = addr_q;
  assign ram_addr_b = addr_q;

  // Next state and next values of every registered output
  always_comb begin
    state_d     = state;
    addr_d      = addr_q;
    data_a_d    = ram_data_a;
    data_b_d    = ram_data_b;
    we_a_d      = 1'b0;
    we_b_d      = 1'b0;
    ack_d       = 1'b0;
    dat_d       = '0;
    fill_pend_d = fill_pend;
    gen_load    = 1'b0;
    gen_step    = 1'b0;

    case (state)
      IDLE: begin
        if (req_hit_c) begin
          if (ram_win_c) begin
            addr_d = wbs_adr_i[2 +: AW];
            if (wbs_we_i) begin
              state_d  = WR;
              we_a_d   = wbs_sel_i[0];
              we_b_d   = wbs_sel_i[1];
              data_a_d = DW'(wbs_dat_i[7:0]);
              data_b_d = DW'(wbs_dat_i[15:8]);
            end else begin
              state_d = RD;
            end
          end else begin
            state_d = ACK;
            ack_d   = 1'b1;
            if (ctrl_hit_c && !wbs_we_i) begin
              dat_d = {31'h0, busy_o};
            end
            if (fill_req_c) begin
              fill_pend_d = 1'b1;
              gen_load    = 1'b1;
            end
          end
        end
      end
      WR: begin
        state_d = ACK;
        ack_d   = 1'b1;
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        state_d = ACK;
        ack_d   = 1'b1;
        dat_d   = {16'h0, 8'(ram_q_b), 8'(ram_q_a)};
      end
      ACK: begin
        state_d = fill_pend ? FILL : IDLE;
        fill_pend_d = 1'b0;
      end
      FILL: begin
        state_d = gen_done ? IDLE : FILL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // One fill address per cycle while FILL is being entered or continued
    if (state_d == FILL) begin
      addr_d   = gen_idx;
      data_a_d = gen_pat_a;
      data_b_d = gen_pat_b;
      we_a_d   = 1'b1;
      we_b_d   = 1'b1;
      gen_step = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: doc/wb_ram_bridge.md
WB_RAM_BRIDGE -- requirements
Module: wb_ram_bridge

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000: Wishbone base; only bits [31:12] are decoded.
REQ-002 Parameter AW, default 6: RAM address width (64 entries per port).
REQ-003 Parameter DW, default 8: RAM data width per port.
REQ-004 Ports: clk in 1, the only clock; rst_n in 1, reset that is synchronous and active-low.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i in 1 each; wbs_sel_i in 4; wbs_adr_i in 32; wbs_dat_i in 32: Wishbone classic slave request.
REQ-006 wbs_ack_o out 1; wbs_dat_o out 32: Wishbone response.
REQ-007 ram_addr_a, ram_addr_b out AW: dual-port RAM addresses.
REQ-008 ram_data_a, ram_data_b out DW; ram_we_a, ram_we_b out 1: RAM write data and enables.
REQ-009 ram_q_a, ram_q_b in DW: RAM read data, registered in the RAM, valid one clk after address.
REQ-010 busy_o out 1: high while a fill runs or a transaction is in flight.

Function
REQ-011 A request is accepted only in IDLE with cyc&stb high and wbs_adr_i[31:12]==BASE_ADDR[31:12]; otherwise the bridge ignores it and never acks.
REQ-012 RAM window is adr[8]==0: word index adr[7:2] drives both ram_addr_a and ram_addr_b; byte 0 maps to port A, byte 1 to port B.
REQ-013 CTRL register is adr[8]==1, adr[7:2]==0; any other in-base address is acked, reads return 0, writes have no effect.
REQ-014 FSM states: IDLE, WR, RD, CAP, ACK, FILL.
REQ-015 RAM write: IDLE->WR (ram_we_a=sel[0], ram_we_b=sel[1] for exactly one cycle)->ACK->IDLE; ack is high in the second cycle after acceptance.
REQ-016 RAM read: IDLE->RD (address driven)->CAP (latch {16'h0,q_b,q_a})->ACK->IDLE; ack is high in the third cycle after acceptance.
REQ-017 wbs_ack_o is a single-cycle pulse; wbs_dat_o holds captured data during ack and is 0 otherwise.
REQ-018 CTRL write with sel[0]&dat[0]: seed=dat[15:8], go to FILL after ACK. Any other CTRL write is acked without effect.
REQ-019 CTRL read returns {31'h0, busy_o}.
REQ-020 FILL: counter i runs 0..2^AW-1, one address per cycle; port A writes seed+i, port B writes ~(seed+i), both at address i, modulo 2^DW.
REQ-021 FILL ends after i==2^AW-1 is written (64 cycles by default), then goes to IDLE; the counter does not wrap into a second pass.
REQ-022 Requests arriving during FILL are stalled with no ack until IDLE; they are then accepted normally.
REQ-023 If cyc drops before ack, the in-flight RAM access completes, the ack pulse is still generated, and the FSM returns to IDLE.
REQ-024 ram_we_a and ram_we_b are 0 in every state except WR and FILL.

Reset
REQ-025 While rst_n is low at a clk edge: FSM=IDLE, counter=0, seed=0, wbs_ack_o=0, wbs_dat_o=0, ram_we_*=0, ram_addr_*=0, ram_data_*=0, busy_o=0.
REQ-026 Reset mid-FILL or mid-transaction aborts it immediately with no ack; RAM contents already written are not restored.

Structure
REQ-027 State encoding, CTRL offset, and field positions (start bit, seed byte) are defined in a shared package, pes_ram_pkg.
REQ-028 The fill address/pattern generator is one sub-module, ram_fill_gen (counter, seed, done flag); the rest is flat.

Verification
REQ-029 Write 0x0000_5A3C to BASE+0x10 with sel=4'b0011 -> one cycle with we_a=we_b=1, addr=4, data_a=0x3C, data_b=0x5A; ack 2 cycles after acceptance.
REQ-030 Read BASE+0x10 after REQ-029 with RAM model -> wbs_dat_o=0x0000_5A3C with ack 3 cycles after acceptance.
REQ-031 Write with sel=4'b0010 to word 7 -> only we_b pulses; a later read shows port A unchanged.
REQ-032 CTRL write dat=0x0000_F001 -> 64 fill cycles; addr 0 gets A=0xF0/B=0x0F, addr 63 gets A=0x2F/B=0xD0 (wraps mod 256); busy_o high throughout; a read issued mid-fill is acked only after fill ends.
REQ-033 Request to 0x4000_0010 -> no ack and no RAM enables; request to BASE+0x104 -> ack with data 0.
REQ-034 rst_n low at fill cycle 20 -> we_* low the next cycle, busy_o=0, no ack; a subsequent normal read succeeds.
